// File: rtl/fifo_writer_if.sv
// Producer handshake and memory write channel of the FIFO writer.
//   wr_valid/wr_data -> producer offers a word
//   wr_ready         <- writer accepts this cycle
//   mem_we/addr/wdata <- registered write port into the FIFO storage
// master: producer / memory side; slave: the fifo_writer itself.
interface fifo_writer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/fifo_writer.sv
// Write side of a same-clock FIFO: accepts producer words, writes them into
// storage one cycle later and advances a wrap-bit write pointer.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   en            writer enable (IDLE <-> RUN/FULL)
//   clr           synchronous discard: wr_ptr <= rd_ptr, clears overflow
//   bus           handshake + memory write channel (fifo_writer_if.slave)
//   rd_ptr        reader pointer incl. wrap bit
//   wr_ptr        writer pointer incl. wrap bit
//   full, level   combinational occupancy status
//   overflow      sticky: write attempted while not ready in RUN/FULL
module fifo_writer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_DATA   = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    fifo_writer_if.slave          bus,
    input  logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [ADDR_WIDTH:0]   wr_ptr,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_DATA - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t                state;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [PTR_W-1:0]      ptr_inc;
    logic                  accept;
    logic                  active;

    // Occupancy: wrap bits differ with equal low bits means full.
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign level = wr_ptr - rd_ptr;

    // Ready looks at the current rd_ptr, so a read in the same cycle as a
    // full condition only frees space for the following cycle.
    assign bus.wr_ready = (state == RUN) && !full && !clr;
    assign accept       = bus.wr_valid && bus.wr_ready;
    assign active       = (state == RUN) || (state == FULL);

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Pointer increment: toggle the wrap bit when the low bits leave the last slot.
    always_comb begin
        ptr_inc = wr_ptr + PTR_W'(1);
        if (wr_ptr[ADDR_WIDTH-1:0] == LAST_ADDR) begin
            ptr_inc = {~wr_ptr[ADDR_WIDTH], {ADDR_WIDTH{1'b0}}};
        end
    end

    // FSM, pointer, memory write port and overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (en) state <= RUN;
                RUN: begin
                    if (!en)       state <= IDLE;
                    else if (full) state <= FULL;
                end
                FULL: begin
                    if (!en)        state <= IDLE;
                    else if (!full) state <= RUN;
                end
                default: state <= IDLE;
            endcase

            // clr wins over an accept and also clears the sticky flag.
            if (clr) begin
                wr_ptr   <= rd_ptr;
                mem_we_q <= 1'b0;
                overflow <= 1'b0;
            end else begin
                mem_we_q <= accept;
                if (accept) begin
                    wr_ptr      <= ptr_inc;
                    mem_addr_q  <= wr_ptr[ADDR_WIDTH-1:0];
                    mem_wdata_q <= bus.wr_data;
                end
                if (bus.wr_valid && !bus.wr_ready && active) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_writer.sv
// Directed bench for fifo_writer: inputs change on the falling edge, outputs
// are checked on the falling edge after the rising edge has acted.
module tb_fifo_writer;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;

    logic          clk;
    logic          rst;
    logic          en;
    logic          clr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr;
    logic          full;
    logic [AW:0]   level;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_DATA(256)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .bus      (bus),
        .rd_ptr   (rd_ptr),
        .wr_ptr   (wr_ptr),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; clr = 1'b0; rd_ptr = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0;
        @(negedge clk); @(negedge clk); #1;
        n_checks++; if (wr_ptr !== 9'h000) begin n_fail++; $display("FAIL reset_wr_ptr: got %h expected 000", wr_ptr); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
        n_checks++; if (bus.mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 00", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 00", bus.mem_wdata); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 0", bus.wr_ready); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (level !== 9'h000) begin n_fail++; $display("FAIL reset_level: got %h expected 000", level); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_single_write();
        @(negedge clk); en = 1'b1; #1;
        n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL idle_not_ready: got %b expected 0", bus.wr_ready); end
        @(negedge clk); #1;
        n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL run_ready: got %b expected 1", bus.wr_ready); end
        bus.wr_valid = 1'b1; bus.wr_data = 8'hA5;
        @(negedge clk); bus.wr_valid = 1'b0; #1;
        n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL single_mem_we: got %b expected 1", bus.mem_we); end
        n_checks++; if (bus.mem_addr !== 8'h00) begin n_fail++; $display("FAIL single_mem_addr: got %h expected 00", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 8'hA5) begin n_fail++; $display("FAIL single_mem_wdata: got %h expected a5", bus.mem_wdata); end
        n_checks++; if (wr_ptr !== 9'h001) begin n_fail++; $display("FAIL single_wr_ptr: got %h expected 001", wr_ptr); end
        n_checks++; if (level !== 9'h001) begin n_fail++; $display("FAIL single_level: got %h expected 001", level); end
        @(negedge clk); #1;
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL single_we_drop: got %b expected 0", bus.mem_we); end
        n_checks++; if (bus.mem_wdata !== 8'hA5) begin n_fail++; $display("FAIL single_wdata_hold: got %h expected a5", bus.mem_wdata); end
    endtask

    task automatic test_fill();
        int drops = 0;
        for (int i = 1; i < 256; i++) begin
            @(negedge clk);
            bus.wr_valid = 1'b1; bus.wr_data = 8'(i);
            #1; if (bus.wr_ready !== 1'b1) drops++;
        end
        @(negedge clk); bus.wr_data = 8'hEE; #1;
        n_checks++; if (drops !== 0) begin n_fail++; $display("FAIL fill_ready_drops: got %0d expected 0", drops); end
        n_checks++; if (wr_ptr !== 9'h100) begin n_fail++; $display("FAIL fill_wr_ptr: got %h expected 100", wr_ptr); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", full); end
        n_checks++; if (level !== 9'h100) begin n_fail++; $display("FAIL fill_level: got %h expected 100", level); end
        n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_not_ready: got %b expected 0", bus.wr_ready); end
        n_checks++; if (bus.mem_addr !== 8'hFF) begin n_fail++; $display("FAIL fill_last_addr: got %h expected ff", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 8'hFF) begin n_fail++; $display("FAIL fill_last_data: got %h expected ff", bus.mem_wdata); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf_yet: got %b expected 0", overflow); end
        @(negedge clk); #1;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got %b expected 1", overflow); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_no_we: got %b expected 0", bus.mem_we); end
        n_checks++; if (wr_ptr !== 9'h100) begin n_fail++; $display("FAIL fill_ptr_held: got %h expected 100", wr_ptr); end
        bus.wr_valid = 1'b0;
    endtask

    task automatic test_read_release();
        @(negedge clk); rd_ptr = 9'h001; #1;
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL release_full: got %b expected 0", full); end
        n_checks++; if (level !== 9'h0FF) begin n_fail++; $display("FAIL release_level: got %h expected 0ff", level); end
        @(negedge clk); #1;
        n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", bus.wr_ready); end
        bus.wr_valid = 1'b1; bus.wr_data = 8'h3C;
        @(negedge clk); bus.wr_valid = 1'b0; #1;
        n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL release_we: got %b expected 1", bus.mem_we); end
        n_checks++; if (bus.mem_addr !== 8'h00) begin n_fail++; $display("FAIL release_addr: got %h expected 00", bus.mem_addr); end
        n_checks++; if (wr_ptr !== 9'h101) begin n_fail++; $display("FAIL release_wr_ptr: got %h expected 101", wr_ptr); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL release_refull: got %b expected 1", full); end
        // read and write together at full: write must wait one cycle
        @(negedge clk); bus.wr_valid = 1'b1; bus.wr_data = 8'h4D; rd_ptr = 9'h002; #1;
        n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL simul_ready: got %b expected 0", bus.wr_ready); end
        @(negedge clk); #1;
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL simul_no_we: got %b expected 0", bus.mem_we); end
        n_checks++; if (wr_ptr !== 9'h101) begin n_fail++; $display("FAIL simul_ptr_held: got %h expected 101", wr_ptr); end
        n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL simul_resume_ready: got %b expected 1", bus.wr_ready); end
        @(negedge clk); bus.wr_valid = 1'b0; #1;
        n_checks++; if (bus.mem_addr !== 8'h01) begin n_fail++; $display("FAIL simul_addr: got %h expected 01", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 8'h4D) begin n_fail++; $display("FAIL simul_data: got %h expected 4d", bus.mem_wdata); end
        n_checks++; if (wr_ptr !== 9'h102) begin n_fail++; $display("FAIL simul_wr_ptr: got %h expected 102", wr_ptr); end
    endtask

    task automatic test_clr();
        @(negedge clk); rd_ptr = 9'h0F8; #1;
        n_checks++; if (level !== 9'h00A) begin n_fail++; $display("FAIL clr_pre_level: got %h expected 00a", level); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_pre_ovf: got %b expected 1", overflow); end
        @(negedge clk); clr = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 8'h77; #1;
        n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready: got %b expected 0", bus.wr_ready); end
        @(negedge clk); clr = 1'b0; bus.wr_valid = 1'b0; #1;
        n_checks++; if (wr_ptr !== 9'h0F8) begin n_fail++; $display("FAIL clr_wr_ptr: got %h expected 0f8", wr_ptr); end
        n_checks++; if (level !== 9'h000) begin n_fail++; $display("FAIL clr_level: got %h expected 000", level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b expected 0", overflow); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL clr_mem_we: got %b expected 0", bus.mem_we); end
    endtask

    task automatic test_wrap();
        @(negedge clk); rd_ptr = 9'h0FF; clr = 1'b1;
        @(negedge clk); clr = 1'b0; rd_ptr = 9'h0FE; #1;
        n_checks++; if (wr_ptr !== 9'h0FF) begin n_fail++; $display("FAIL wrap_pre_ptr: got %h expected 0ff", wr_ptr); end
        n_checks++; if (level !== 9'h001) begin n_fail++; $display("FAIL wrap_pre_level: got %h expected 001", level); end
        bus.wr_valid = 1'b1; bus.wr_data = 8'h5A;
        @(negedge clk); bus.wr_valid = 1'b0; #1;
        n_checks++; if (bus.mem_addr !== 8'hFF) begin n_fail++; $display("FAIL wrap_addr: got %h expected ff", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 8'h5A) begin n_fail++; $display("FAIL wrap_data: got %h expected 5a", bus.mem_wdata); end
        n_checks++; if (wr_ptr !== 9'h100) begin n_fail++; $display("FAIL wrap_wr_ptr: got %h expected 100", wr_ptr); end
        n_checks++; if (level !== 9'h002) begin n_fail++; $display("FAIL wrap_level: got %h expected 002", level); end
    endtask

    task automatic test_idle_no_overflow();
        @(negedge clk); en = 1'b0;
        @(negedge clk); bus.wr_valid = 1'b1; #1;
        n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b expected 0", bus.wr_ready); end
        @(negedge clk); @(negedge clk); #1;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL idle_overflow: got %b expected 0", overflow); end
        n_checks++; if (wr_ptr !== 9'h100) begin n_fail++; $display("FAIL idle_ptr: got %h expected 100", wr_ptr); end
        bus.wr_valid = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk); bus.wr_valid = 1'b1; bus.wr_data = 8'hC3; #1;
        n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", bus.wr_ready); end
        @(negedge clk); bus.wr_valid = 1'b0; #1;
        n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL midrst_we_before: got %b expected 1", bus.mem_we); end
        rd_ptr = '0; rst = 1'b0; #1;
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we_drop: got %b expected 0", bus.mem_we); end
        n_checks++; if (wr_ptr !== 9'h000) begin n_fail++; $display("FAIL midrst_wr_ptr: got %h expected 000", wr_ptr); end
        n_checks++; if (bus.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL midrst_wdata: got %h expected 00", bus.mem_wdata); end
        n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready_low: got %b expected 0", bus.wr_ready); end
        n_checks++; if (level !== 9'h000) begin n_fail++; $display("FAIL midrst_level: got %h expected 000", level); end
        @(negedge clk); rst = 1'b1; #1;
        n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 0", bus.wr_ready); end
        @(negedge clk); #1;
        n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_run: got %b expected 1", bus.wr_ready); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill();
        test_read_release();
        test_clr();
        test_wrap();
        test_idle_no_overflow();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_writer.md
FIFO_WRITER -- requirements
Module: fifo_writer

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_WIDTH, 8, width of the write data and memory data
  ADDR_WIDTH, 8, width of the memory address
  MAX_DATA, 256, FIFO depth (SHALL equal 2**ADDR_WIDTH)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  single clock; all state updates on the rising edge
  rst  input  1  asynchronous, active-low reset
  en  input  1  writer enable
  clr  input  1  synchronous discard: drop all unread entries
  wr_valid  input  1  producer has data
  wr_data  input  DATA_WIDTH  producer data
  wr_ready  output  1  writer accepts this cycle
  rd_ptr  input  ADDR_WIDTH+1  reader pointer incl. wrap bit, same clock domain
  wr_ptr  output  ADDR_WIDTH+1  writer pointer incl. wrap bit
  mem_we  output  1  memory write strobe
  mem_addr  output  ADDR_WIDTH  memory write address
  mem_wdata  output  DATA_WIDTH  memory write data
  full  output  1  FIFO full
  level  output  ADDR_WIDTH+1  occupied entries
  overflow  output  1  sticky: write attempted while not ready in RUN/FULL

Function
REQ-003 The FSM SHALL have states IDLE, RUN, FULL.
REQ-004 IDLE -> RUN when en=1; RUN/FULL -> IDLE when en=0 (takes priority over RUN<->FULL).
REQ-005 RUN -> FULL when full=1; FULL -> RUN when full=0.
REQ-006 full SHALL be combinational: wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH] and the low ADDR_WIDTH bits are equal.
REQ-007 level SHALL be (wr_ptr - rd_ptr) modulo 2**(ADDR_WIDTH+1) and SHALL range 0..MAX_DATA.
REQ-008 wr_ready SHALL be 1 only when state=RUN, full=0 and clr=0.
REQ-009 accept = wr_valid & wr_ready; on accept, the next cycle SHALL have mem_we=1, mem_addr=wr_ptr[ADDR_WIDTH-1:0] (pre-increment value) and mem_wdata=wr_data. Latency is 1 cycle.
REQ-010 On accept, wr_ptr SHALL increment by 1 modulo 2**(ADDR_WIDTH+1); the wrap bit toggles when the low bits wrap from MAX_DATA-1 to 0.
REQ-011 mem_we SHALL be 0 in any cycle not following an accept; mem_addr and mem_wdata SHALL hold their last values.
REQ-012 Simultaneous read and write at full: wr_ready SHALL use the current rd_ptr, so no write occurs that cycle; writing resumes the cycle after rd_ptr advances.
REQ-013 clr=1 SHALL set wr_ptr<=rd_ptr, suppress accept, force the next mem_we=0 and clear overflow. clr has priority over accept and does not change state.
REQ-014 overflow SHALL set when wr_valid=1, wr_ready=0, clr=0 and state is RUN or FULL. It is sticky until reset or clr; wr_valid in IDLE SHALL NOT set it.
REQ-015 The rd_ptr range is not checked; behaviour for level > MAX_DATA is undefined.

Reset
REQ-016 rst=0 SHALL asynchronously force: state=IDLE, wr_ptr=0, mem_we=0, mem_addr=0, mem_wdata=0, overflow=0.
REQ-017 While in reset with rd_ptr=0: wr_ready=0, full=0, level=0.
REQ-018 Reset asserted mid-write SHALL drop the pending mem_we within the same cycle; an in-flight accept is discarded.
REQ-019 After rst deasserts, the first accept SHALL be possible on the first edge where en=1 has already moved the FSM to RUN, i.e. at least 1 cycle after en rises.

Verification
REQ-020 Reset, en=1, rd_ptr=0, write 0xA5 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0xA5; wr_ptr=1, level=1.
REQ-021 256 writes with rd_ptr=0 -> wr_ptr=0x100, full=1, state=FULL, wr_ready=0, level=256; the 257th wr_valid sets overflow=1 and mem_we stays 0.
REQ-022 At full, rd_ptr steps to 1 -> full=0 and wr_ready=1; the next write goes to mem_addr=0 and wr_ptr becomes 0x101.
REQ-023 wr_ptr=0x0FF, rd_ptr=0x0FE, write -> mem_addr=0xFF and wr_ptr=0x100 (wrap bit set); level goes from 1 to 2.
REQ-024 level=10 with overflow=1, assert clr for 1 cycle together with wr_valid -> wr_ptr=rd_ptr, level=0, overflow=0, no mem_we the next cycle.
REQ-025 rst pulled low in the cycle after an accept -> mem_we drops immediately and all outputs match REQ-016/017.
